// File: rtl/norm_pkg.sv
// norm_pkg: shared widths, lane result type and saturation constants for
// block_normalizer and norm_lane.
package norm_pkg;

   localparam int unsigned NORM_SIG_W   = 4;
   localparam int unsigned NORM_EXP_W   = 4;
   localparam int unsigned NORM_LOW_EXP = 2;
   localparam int unsigned NORM_LANES   = 4;

   // Per-lane accumulated input width (sign + integer headroom + fraction + guard)
   function automatic int unsigned norm_w(input int unsigned sig_w,
                                          input int unsigned low_exp);
      return sig_w + 4 + low_exp;
   endfunction

   // Bit index of the hidden one within the magnitude
   function automatic int unsigned norm_h(input int unsigned sig_w,
                                          input int unsigned low_exp);
      return sig_w + low_exp;
   endfunction

   typedef struct packed {
      logic                  sign;
      logic [NORM_EXP_W-1:0] exp;
      logic [NORM_SIG_W-1:0] mant;
      logic                  zero;
      logic                  ovf;
   } lane_res_t;

   localparam logic [NORM_EXP_W-1:0] NORM_SAT_EXP  = NORM_EXP_W'((1 << NORM_EXP_W) - 2);
   localparam logic [NORM_SIG_W-1:0] NORM_SAT_MANT = '1;

endpackage

// File: rtl/norm_lane.sv
// norm_lane: combinational normalize step for one lane -- leading-one detect,
// left-align, exponent adjust and optional round-to-nearest-even.
// Rounding is built only when NORM_RNE_EN is defined; otherwise truncation.
module norm_lane
   import norm_pkg::*;
#(
   parameter  int unsigned sigWidth   = NORM_SIG_W,
   parameter  int unsigned expWidth   = NORM_EXP_W,
   parameter  int unsigned low_expand = NORM_LOW_EXP,
   localparam int unsigned W          = norm_w(sigWidth, low_expand)
) (
   input  logic                sign_i,
   input  logic                zero_i,
   input  logic                ovf_i,
   input  logic [W-2:0]        mag_i,
   input  logic [expWidth-1:0] blk_exp_i,
   output lane_res_t           res_o
);

   localparam int unsigned MW  = W - 1;
   localparam int unsigned H   = norm_h(sigWidth, low_expand);
   localparam int unsigned EW2 = expWidth + 2;
   localparam int unsigned PW  = $clog2(MW);
   localparam int unsigned RW  = MW - 1 - sigWidth;

   localparam logic signed [EW2-1:0] E_SAT  = EW2'((1 << expWidth) - 1);
   localparam logic signed [EW2-1:0] E_ZERO = '0;

   logic [PW-1:0]         lead_pos;
   logic [PW-1:0]         shamt;
   logic [sigWidth-1:0]   mant_t;
   logic [sigWidth-1:0]   mant_r;
   logic signed [EW2-1:0] exp_raw;
   logic signed [EW2-1:0] exp_adj;

   // Leading-one detector: highest set bit wins
   always_comb begin
      lead_pos = '0;
      for (int unsigned i = 0; i < MW; i++) begin
         if (mag_i[i]) lead_pos = PW'(i);
      end
   end

   // Left-align the leading one to the top bit; take the bits just below it
   always_comb begin
      shamt   = PW'(MW - 1) - lead_pos;
      mant_t  = sigWidth'((mag_i << shamt) >> RW);
      exp_raw = EW2'(blk_exp_i) + EW2'(lead_pos) - EW2'(H);
   end

`ifdef NORM_RNE_EN
   logic [RW-1:0]     rbits;
   logic              guard;
   logic              sticky;
   logic              rnd_up;
   logic [sigWidth:0] mant_sum;

   // Round to nearest, ties to even; a carry-out leaves mant at zero and bumps exp
   always_comb begin
      rbits    = RW'(mag_i << shamt);
      guard    = rbits[RW-1];
      sticky   = |rbits[RW-2:0];
      rnd_up   = guard & (sticky | mant_t[0]);
      mant_sum = {1'b0, mant_t} + (sigWidth + 1)'(rnd_up);
      mant_r   = mant_sum[sigWidth-1:0];
      exp_adj  = exp_raw + EW2'(mant_sum[sigWidth]);
   end
`else
   // Plain truncation
   always_comb begin
      mant_r  = mant_t;
      exp_adj = exp_raw;
   end
`endif

   // Special-case selection: saturate, flush to zero, or pass normalized value
   always_comb begin
      res_o = '0;
      if (ovf_i) begin
         res_o.sign = sign_i;
         res_o.exp  = NORM_SAT_EXP;
         res_o.mant = NORM_SAT_MANT;
         res_o.ovf  = 1'b1;
      end else if (zero_i || (exp_adj <= E_ZERO)) begin
         res_o.zero = 1'b1;
      end else if (exp_adj >= E_SAT) begin
         res_o.sign = sign_i;
         res_o.exp  = NORM_SAT_EXP;
         res_o.mant = NORM_SAT_MANT;
         res_o.ovf  = 1'b1;
      end else begin
         res_o.sign = sign_i;
         res_o.exp  = exp_adj[expWidth-1:0];
         res_o.mant = mant_r;
      end
   end

endmodule

// File: rtl/block_normalizer.sv
// block_normalizer: four-lane fixed-point to sign/exp/mant normalizer.
// Stage 1 decodes sign/magnitude, stage 2 (norm_lane x4) normalizes into the
// output registers. Valid/ready on both sides; one bundle per cycle.
// Define NORM_RNE_EN for round-to-nearest-even instead of truncation.
module block_normalizer
   import norm_pkg::*;
#(
   parameter  int unsigned sigWidth   = NORM_SIG_W,
   parameter  int unsigned expWidth   = NORM_EXP_W,
   parameter  int unsigned low_expand = NORM_LOW_EXP,
   localparam int unsigned W          = norm_w(sigWidth, low_expand)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*W-1:0]        in_num,
   input  logic [expWidth-1:0]   in_exp,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [3:0]            out_sign,
   output logic [4*expWidth-1:0] out_exp,
   output logic [4*sigWidth-1:0] out_mant,
   output logic [3:0]            out_zero,
   output logic [3:0]            out_ovf
);

   logic s1_adv;
   logic accept;

   logic [NORM_LANES-1:0]        dec_sign;
   logic [NORM_LANES-1:0]        dec_zero;
   logic [NORM_LANES-1:0]        dec_ovf;
   logic [NORM_LANES-1:0][W-2:0] dec_mag;

   logic                         s1_valid_q, s1_valid_d;
   logic [expWidth-1:0]          s1_exp_q,   s1_exp_d;
   logic [NORM_LANES-1:0]        s1_sign_q,  s1_sign_d;
   logic [NORM_LANES-1:0]        s1_zero_q,  s1_zero_d;
   logic [NORM_LANES-1:0]        s1_ovf_q,   s1_ovf_d;
   logic [NORM_LANES-1:0][W-2:0] s1_mag_q,   s1_mag_d;

   lane_res_t [NORM_LANES-1:0]   lane_res;
   lane_res_t [NORM_LANES-1:0]   out_res_q,   out_res_d;
   logic                         out_valid_q, out_valid_d;

   // Handshake: stage 1 drains whenever the output slot is empty or being taken
   always_comb begin
      s1_adv   = !out_valid_q || out_ready;
      in_ready = !s1_valid_q || s1_adv;
      accept   = in_valid && in_ready;
   end

   // Stage 1 decode: two's complement to sign/magnitude; most-negative saturates
   always_comb begin
      for (int unsigned i = 0; i < NORM_LANES; i++) begin
         dec_sign[i] = in_num[W*i + W-1];
         dec_mag[i]  = in_num[W*i +: W-1];
         dec_ovf[i]  = 1'b0;
         dec_zero[i] = (in_num[W*i +: W-1] == '0) && !dec_sign[i];
         if (dec_sign[i]) begin
            if (in_num[W*i +: W-1] == '0) begin
               dec_mag[i] = '1;
               dec_ovf[i] = 1'b1;
            end else begin
               dec_mag[i] = ~in_num[W*i +: W-1] + (W-1)'(1);
            end
         end
      end
   end

   // Stage 1 register next-state: load on accept, valid follows in_valid when ready
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_exp_d   = s1_exp_q;
      s1_sign_d  = s1_sign_q;
      s1_zero_d  = s1_zero_q;
      s1_ovf_d   = s1_ovf_q;
      s1_mag_d   = s1_mag_q;
      if (in_ready) s1_valid_d = in_valid;
      if (accept) begin
         s1_exp_d  = in_exp;
         s1_sign_d = dec_sign;
         s1_zero_d = dec_zero;
         s1_ovf_d  = dec_ovf;
         s1_mag_d  = dec_mag;
      end
   end

   for (genvar g = 0; g < NORM_LANES; g++) begin : g_lane
      norm_lane #(
         .sigWidth   (sigWidth),
         .expWidth   (expWidth),
         .low_expand (low_expand)
      ) u_lane (
         .sign_i    (s1_sign_q[g]),
         .zero_i    (s1_zero_q[g]),
         .ovf_i     (s1_ovf_q[g]),
         .mag_i     (s1_mag_q[g]),
         .blk_exp_i (s1_exp_q),
         .res_o     (lane_res[g])
      );
   end

   // Output register next-state: moves only on s1_adv, so held data stays stable
   always_comb begin
      out_valid_d = out_valid_q;
      out_res_d   = out_res_q;
      if (s1_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) out_res_d = lane_res;
      end
   end

   // Pipeline registers; reset drops both in-flight bundles
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_exp_q    <= '0;
         s1_sign_q   <= '0;
         s1_zero_q   <= '0;
         s1_ovf_q    <= '0;
         s1_mag_q    <= '0;
         out_valid_q <= 1'b0;
         out_res_q   <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_exp_q    <= s1_exp_d;
         s1_sign_q   <= s1_sign_d;
         s1_zero_q   <= s1_zero_d;
         s1_ovf_q    <= s1_ovf_d;
         s1_mag_q    <= s1_mag_d;
         out_valid_q <= out_valid_d;
         out_res_q   <= out_res_d;
      end
   end

   // Flatten the lane results onto the output buses
   always_comb begin
      out_valid = out_valid_q;
      for (int unsigned i = 0; i < NORM_LANES; i++) begin
         out_sign[i]                      = out_res_q[i].sign;
         out_exp[i*expWidth +: expWidth]  = out_res_q[i].exp;
         out_mant[i*sigWidth +: sigWidth] = out_res_q[i].mant;
         out_zero[i]                      = out_res_q[i].zero;
         out_ovf[i]                       = out_res_q[i].ovf;
      end
   end

endmodule
